// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: FSM state encoding,
// coin codes and the coin code to cents decoder.
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCredit = 2'b01,
        StVend   = 2'b10,
        StChange = 2'b11
    } vend_state_e;

    localparam logic [1:0] Coin5   = 2'b00;
    localparam logic [1:0] Coin10  = 2'b01;
    localparam logic [1:0] Coin25  = 2'b10;
    localparam logic [1:0] Coin100 = 2'b11;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        logic [6:0] v;
        unique case (code)
            Coin5:   v = 7'd5;
            Coin10:  v = 7'd10;
            Coin25:  v = 7'd25;
            Coin100: v = 7'd100;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters with decrement on vend, refill to full on restock,
// and a sold-out flag derived directly from each counter.
module vend_stock
    import vend_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 3,
    parameter int unsigned IDX_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_dec_valid,
    input  logic [IDX_W-1:0]   i_dec_idx,
    input  logic               i_restock_valid,
    input  logic [IDX_W-1:0]   i_restock_idx,
    output logic [N_ITEMS-1:0] o_sold_out
);

    logic [STOCK_W-1:0] r_stock [N_ITEMS];

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end else if (i_restock_valid && (i_restock_idx == IDX_W'(i))) begin
                r_stock[i] <= '1;
            end else if (i_dec_valid && (i_dec_idx == IDX_W'(i)) && (r_stock[i] != '0)) begin
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end
        end

        assign o_sold_out[i] = (r_stock[i] == '0);
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: Moore FSM with saturating credit, per-item
// prices, change return and an inactivity refund timer.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int unsigned                  N_ITEMS    = 4,
    parameter int unsigned                  CREDIT_W   = 8,
    parameter int unsigned                  STOCK_W    = 4,
    parameter int unsigned                  INIT_STOCK = 3,
    parameter logic [N_ITEMS*CREDIT_W-1:0]  PRICES     = {8'd100, 8'd75, 8'd50, 8'd25},
    parameter int unsigned                  TIMEOUT    = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_code,
    input  logic                         sel_valid,
    input  logic [$clog2(N_ITEMS)-1:0]   sel_idx,
    input  logic                         cancel,
    input  logic                         restock_valid,
    input  logic [$clog2(N_ITEMS)-1:0]   restock_idx,
    output logic [1:0]                   state,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         vend_valid,
    output logic [$clog2(N_ITEMS)-1:0]   vend_idx,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic                         coin_reject,
    output logic                         sel_reject,
    output logic [N_ITEMS-1:0]           sold_out
);

    localparam int unsigned        IDX_W      = $clog2(N_ITEMS);
    localparam int unsigned        TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CREDIT_W:0]  CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    vend_state_e         r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change_amt;
    logic                r_vend_valid;
    logic                r_change_valid;
    logic                r_coin_reject;
    logic                r_sel_reject;
    logic [IDX_W-1:0]    r_vend_idx;
    logic [TO_W-1:0]     r_idle_cnt;

    logic [CREDIT_W-1:0] w_price_tbl [N_ITEMS];
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_fits;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;
    logic                w_dec_valid;
    logic                w_restock_valid;
    logic [N_ITEMS-1:0]  w_sold_out;

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            w_price_tbl[i] = PRICES[i*CREDIT_W +: CREDIT_W];
        end
        // One extra bit so an overflowing coin can be detected before it wraps.
        w_coin_sum      = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(coin_code));
        w_coin_fits     = (w_coin_sum <= CREDIT_MAX);
        w_price         = w_price_tbl[sel_idx];
        w_sel_ok        = (r_credit >= w_price) && !w_sold_out[sel_idx];
        w_dec_valid     = (r_state == StCredit) && !cancel && sel_valid && w_sel_ok;
        w_restock_valid = (r_state == StIdle) && restock_valid;
    end

    vend_stock #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .IDX_W      (IDX_W)
    ) u_stock (
        .clk             (clk),
        .rst             (rst),
        .i_dec_valid     (w_dec_valid),
        .i_dec_idx       (sel_idx),
        .i_restock_valid (w_restock_valid),
        .i_restock_idx   (restock_idx),
        .o_sold_out      (w_sold_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= StIdle;
            r_credit       <= '0;
            r_change_amt   <= '0;
            r_vend_valid   <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sel_reject   <= 1'b0;
            r_vend_idx     <= '0;
            r_idle_cnt     <= '0;
        end else begin
            r_vend_valid   <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_coin_reject  <= 1'b0;
            r_sel_reject   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (coin_valid) begin
                        if (w_coin_fits) begin
                            r_credit   <= w_coin_sum[CREDIT_W-1:0];
                            r_idle_cnt <= '0;
                            r_state    <= StCredit;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                StCredit: begin
                    if (cancel) begin
                        r_state        <= StChange;
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                    end else if (sel_valid) begin
                        if (w_sel_ok) begin
                            r_state      <= StVend;
                            r_vend_valid <= 1'b1;
                            r_vend_idx   <= sel_idx;
                            r_credit     <= r_credit - w_price;
                        end else begin
                            r_sel_reject <= 1'b1;
                            r_idle_cnt   <= '0;
                        end
                    end else if (coin_valid && w_coin_fits) begin
                        r_credit   <= w_coin_sum[CREDIT_W-1:0];
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == TO_LAST) begin
                        // A rejected coin does not restart the timer.
                        r_coin_reject  <= coin_valid;
                        r_state        <= StChange;
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                    end else begin
                        r_coin_reject <= coin_valid;
                        r_idle_cnt    <= r_idle_cnt + TO_W'(1);
                    end
                end
                StVend: begin
                    r_coin_reject <= coin_valid;
                    if (r_credit != '0) begin
                        r_state        <= StChange;
                        r_change_valid <= 1'b1;
                        r_change_amt   <= r_credit;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StChange: begin
                    r_coin_reject <= coin_valid;
                    r_credit      <= '0;
                    r_state       <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign state        = r_state;
    assign credit       = r_credit;
    assign vend_valid   = r_vend_valid;
    assign vend_idx     = r_vend_idx;
    assign change_valid = r_change_valid;
    assign change_amt   = r_change_amt;
    assign coin_reject  = r_coin_reject;
    assign sel_reject   = r_sel_reject;
    assign sold_out     = w_sold_out;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Randomised bench for vend_ctrl_multi against a cents-and-counters reference
// model, with directed scenarios carrying hand-computed expectations.
module tb_vend_ctrl_multi;

    localparam int N       = 4;
    localparam int TIMEOUT = 20;
    localparam int CMAX    = 255;
    localparam int SMAX    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid, sel_valid, cancel, restock_valid;
    logic [1:0] coin_code, sel_idx, restock_idx;
    logic [1:0] state;
    logic [7:0] credit, change_amt;
    logic       vend_valid, change_valid, coin_reject, sel_reject;
    logic [1:0] vend_idx;
    logic [3:0] sold_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int coin_tbl[4]  = '{5, 10, 25, 100};
    int price_tbl[4] = '{25, 50, 75, 100};

    // Model: phase 0=idle, 1=holding credit, 2=dispensing, 3=returning change.
    int m_state, m_credit, m_since, m_vidx, m_amt;
    int m_stock[N];
    bit m_vend, m_chg, m_crej, m_srej;

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .N_ITEMS    (4),
        .CREDIT_W   (8),
        .STOCK_W    (4),
        .INIT_STOCK (3),
        .PRICES     ({8'd100, 8'd75, 8'd50, 8'd25}),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .state         (state),
        .credit        (credit),
        .vend_valid    (vend_valid),
        .vend_idx      (vend_idx),
        .change_valid  (change_valid),
        .change_amt    (change_amt),
        .coin_reject   (coin_reject),
        .sel_reject    (sel_reject),
        .sold_out      (sold_out)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_since = 0; m_vidx = 0; m_amt = 0;
        m_vend = 0; m_chg = 0; m_crej = 0; m_srej = 0;
        for (int i = 0; i < N; i++) m_stock[i] = 3;
    endtask

    task automatic refund();
        m_state = 3; m_chg = 1; m_amt = m_credit;
    endtask

    task automatic model_step();
        int cval, price;
        bit fits;
        m_vend = 0; m_chg = 0; m_amt = 0; m_crej = 0; m_srej = 0;
        cval = coin_tbl[coin_code];
        fits = (m_credit + cval) <= CMAX;
        case (m_state)
            0: begin
                if (restock_valid) m_stock[restock_idx] = SMAX;
                if (coin_valid) begin
                    if (fits) begin m_credit += cval; m_state = 1; m_since = 0; end
                    else m_crej = 1;
                end
            end
            1: begin
                if (cancel) refund();
                else if (sel_valid) begin
                    price = price_tbl[sel_idx];
                    if (m_credit >= price && m_stock[sel_idx] > 0) begin
                        m_credit -= price; m_stock[sel_idx]--;
                        m_state = 2; m_vend = 1; m_vidx = int'(sel_idx);
                    end else begin
                        m_srej = 1; m_since = 0;
                    end
                end else if (coin_valid && fits) begin
                    m_credit += cval; m_since = 0;
                end else begin
                    m_crej = coin_valid;
                    m_since++;
                    if (m_since == TIMEOUT) refund();
                end
            end
            2: begin
                m_crej = coin_valid;
                if (m_credit > 0) refund(); else m_state = 0;
            end
            default: begin
                m_crej = coin_valid; m_credit = 0; m_state = 0;
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int so;
            so = 0;
            for (int i = 0; i < N; i++) if (m_stock[i] == 0) so |= (1 << i);
            chk("state", int'(state), m_state);
            chk("credit", int'(credit), m_credit);
            chk("vend_valid", int'(vend_valid), int'(m_vend));
            chk("vend_idx", int'(vend_idx), m_vidx);
            chk("change_valid", int'(change_valid), int'(m_chg));
            chk("change_amt", int'(change_amt), m_amt);
            chk("coin_reject", int'(coin_reject), int'(m_crej));
            chk("sel_reject", int'(sel_reject), int'(m_srej));
            chk("sold_out", int'(sold_out), so);
        end
    end

    task automatic step(input bit cv, input logic [1:0] code, input bit sv, input logic [1:0] si,
                        input bit ca, input bit rv, input logic [1:0] ri);
        coin_valid = cv; coin_code = code; sel_valid = sv; sel_idx = si;
        cancel = ca; restock_valid = rv; restock_idx = ri;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0);
    endtask

    task automatic coin(input logic [1:0] code);
        step(1, code, 0, 2'd0, 0, 0, 2'd0);
    endtask

    task automatic sel(input logic [1:0] idx);
        step(0, 2'd0, 1, idx, 0, 0, 2'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        bit cv, sv, ca, rv;
        logic [1:0] code, si, ri;
        rst = 1'b0;
        coin_valid = 0; coin_code = 0; sel_valid = 0; sel_idx = 0;
        cancel = 0; restock_valid = 0; restock_idx = 0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_sold_out", int'(sold_out), 0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        // 25c buys item 0 exactly.
        coin(2'd2);
        chk("t1_credit", int'(credit), 25);
        sel(2'd0);
        chk("t1_vend", int'(vend_valid), 1);
        chk("t1_vidx", int'(vend_idx), 0);
        idle();
        chk("t1_idle", int'(state), 0);
        chk("t1_nochg", int'(change_valid), 0);

        // 100c for item 2 leaves 25c change.
        coin(2'd3);
        sel(2'd2);
        chk("t2_vend", int'(vend_valid), 1);
        idle();
        chk("t2_chg", int'(change_valid), 1);
        chk("t2_amt", int'(change_amt), 25);
        idle();
        chk("t2_idle", int'(state), 0);

        // Insufficient credit, then cancel.
        coin(2'd1);
        sel(2'd1);
        chk("t3_srej", int'(sel_reject), 1);
        chk("t3_credit", int'(credit), 10);
        step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0);
        chk("t3_amt", int'(change_amt), 10);
        idle();

        // Credit saturation.
        coin(2'd3);
        coin(2'd3);
        coin(2'd3);
        chk("t4_crej", int'(coin_reject), 1);
        chk("t4_credit", int'(credit), 200);
        step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0);
        chk("t4_amt", int'(change_amt), 200);
        idle();

        // Exhaust item 0 (one already sold), reject, then restock.
        for (int k = 0; k < 2; k++) begin
            coin(2'd2);
            sel(2'd0);
            idle();
        end
        chk("t5_soldout", int'(sold_out), 1);
        coin(2'd2);
        sel(2'd0);
        chk("t5_srej", int'(sel_reject), 1);
        step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0);
        idle();
        step(0, 2'd0, 0, 2'd0, 0, 1, 2'd0);
        chk("t5_restock", int'(sold_out), 0);

        // Inactivity refund.
        coin(2'd0);
        for (int k = 0; k < TIMEOUT - 1; k++) idle();
        chk("t6_wait", int'(state), 1);
        idle();
        chk("t6_state", int'(state), 3);
        chk("t6_amt", int'(change_amt), 5);
        idle();

        // Asynchronous reset while holding credit.
        coin(2'd0);
        #2 rst = 1'b0;
        #1;
        chk("t7_state", int'(state), 0);
        chk("t7_credit", int'(credit), 0);
        chk("t7_chg", int'(change_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();

        quiet = 0;
        for (int c = 0; c < 4000; c++) begin
            cv = 0; sv = 0; ca = 0; rv = 0;
            code = 2'($urandom_range(0, 3));
            si   = 2'($urandom_range(0, 3));
            ri   = 2'($urandom_range(0, 3));
            if (quiet > 0) begin
                quiet--;
            end else begin
                if ($urandom_range(0, 59) == 0) quiet = TIMEOUT + 3;
                cv = ($urandom_range(0, 99) < 35);
                sv = ($urandom_range(0, 99) < 20);
                ca = ($urandom_range(0, 99) < 4);
                rv = ($urandom_range(0, 99) < 4);
                // Mixed cancel/select/coin only while credit is held.
                if (m_state != 1) begin
                    if (ca) begin cv = 0; sv = 0; end
                    else if (sv) cv = 0;
                end
            end
            step(cv, code, sv, si, ca, rv, ri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised multi-item vending controller: next generation of the two-input Moore vending FSM. Accepts coded coins into a saturating credit register, vends one of `N_ITEMS` products against per-item prices and stock counters, returns change, and refunds on cancel or inactivity timeout. Sits between the coin acceptor / keypad front end and the dispense and change-return actuators.

## Interface
- `N_ITEMS`, 4: number of product channels (2..16).
- `CREDIT_W`, 8: credit and price width, in cents.
- `STOCK_W`, 4: per-item stock counter width.
- `INIT_STOCK`, 3: stock loaded into every item at reset.
- `PRICES`, {8'd100,8'd75,8'd50,8'd25}: packed `N_ITEMS*CREDIT_W` price vector; item i is at slice i.
- `TIMEOUT`, 100: idle cycles in CREDIT before auto-refund.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  one coin presented this cycle.
- `coin_code`  in  2  coin value: 00=5, 01=10, 10=25, 11=100.
- `sel_valid`  in  1  product selection request.
- `sel_idx`  in  $clog2(N_ITEMS)  selected item.
- `cancel`  in  1  refund request.
- `restock_valid`  in  1  refill request for `restock_idx`.
- `restock_idx`  in  $clog2(N_ITEMS)  item to refill.
- `state`  out  2  FSM state: IDLE=00, CREDIT=01, VEND=10, CHANGE=11.
- `credit`  out  CREDIT_W  current credit.
- `vend_valid` / `vend_idx`  out  1 / $clog2(N_ITEMS)  dispense pulse and item.
- `change_valid` / `change_amt`  out  1 / CREDIT_W  change-return pulse and amount.
- `coin_reject`, `sel_reject`  out  1 each  one-cycle reject pulses.
- `sold_out`  out  N_ITEMS  bit i set while stock[i]==0.

## Operation
- Moore FSM. All outputs are registered; `vend_valid` is high exactly when state==VEND, and `change_valid` exactly when state==CHANGE.
- Input priority in the same cycle: cancel > sel_valid > coin_valid.
- IDLE: an accepted coin loads credit and moves to CREDIT. `cancel` and `sel_valid` are ignored with no pulse. `restock_valid` sets `stock[restock_idx]` to 2^STOCK_W-1 and is honoured only in IDLE.
- CREDIT: accepted coin adds its value to credit. If the sum exceeds 2^CREDIT_W-1, assert `coin_reject` and leave credit unchanged.
- CREDIT, on `sel_valid`:
  - If credit >= PRICES[sel_idx] and stock > 0: go to VEND, credit -= price, stock decrements, latch `vend_idx`.
  - Otherwise: assert `sel_reject` and stay in CREDIT.
- CREDIT, on `cancel`: go to CHANGE.
- CREDIT, timeout: the counter restarts on each accepted coin and each rejected selection. When it reaches TIMEOUT with no event, go to CHANGE.
- VEND lasts one cycle. Then go to CHANGE if credit > 0, else to IDLE.
- CHANGE lasts one cycle with `change_amt`=credit. Then credit clears and the FSM goes to IDLE.
- Coins arriving in VEND or CHANGE are rejected with `coin_reject`. Selections arriving there are ignored.

## Timing
- Reset values: state=IDLE, credit=0, `vend_valid`=0, `vend_idx`=0, `change_valid`=0, `change_amt`=0, both reject pulses 0, stock[i]=INIT_STOCK, `sold_out`=0 (all ones if INIT_STOCK==0).
- Reset is asynchronous. Asserting it mid-transaction abandons credit with no change pulse.
- Latency:
  - Coin edge to credit update: 1 cycle.
  - Selection edge to `vend_valid`: 1 cycle.
  - `vend_valid` to `change_valid`: 1 cycle.
  - `change_valid` to IDLE: 1 cycle.
- Reject pulses appear 1 cycle after the offending input and last exactly 1 cycle.
- `sold_out` updates in the same cycle the stock register changes.
- Timeout: CHANGE is entered TIMEOUT cycles after the last counter restart.

## Structure
- Shared package `vend_pkg` holds:
  - state encodings;
  - coin code values;
  - the `coin_value(code)` function.
- Sub-module `vend_stock` holds the N_ITEMS stock counters. It provides decrement, restock and `sold_out`. The FSM, credit arithmetic and timeout counter stay in the top module.

## Test plan
- Reset, then 25c coin and select item 0 (price 25): VEND with `vend_idx`=0, then IDLE, no `change_valid`, stock[0] = 2.
- 100c coin, select item 2 (price 75): `vend_valid`, then `change_valid` with `change_amt`=25, then IDLE.
- 10c coin, select item 1: `sel_reject`, credit stays 10. Then `cancel`: `change_amt`=10.
- Three coins of 100c: the third gives `coin_reject`, credit stays 200.
- Buy item 0 three times: `sold_out[0]`=1 and a fourth select gives `sel_reject`. Restock in IDLE clears `sold_out[0]`.
- 5c coin then TIMEOUT idle cycles: CHANGE with `change_amt`=5. Repeat with `rst` low while in CREDIT: outputs return to reset values immediately.
